// File: rtl/val2_encoder_pkg.sv
// Shared types, widths and the rotate helper for the Val2 shift_OP encoder.
// rol32 is also used by verification models, so keep its behaviour stable.
package val2_encoder_pkg;

    localparam int SHIFT_OP_W = 12;
    localparam int IMM8_W     = 8;
    localparam int ROT_W      = 4;
    localparam int NUM_ROT    = 16;

    typedef enum logic [1:0] {
        IDLE,
        MEMCHK,
        SEARCH,
        DONE
    } state_t;

    // Rotate left by 0..31; the upper half of the doubled word is the result.
    function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amount);
        logic [63:0] doubled;
        doubled = {value, value} << amount;
        return doubled[63:32];
    endfunction

endpackage

// File: rtl/val2_rot_check.sv
// Combinational test of one rotate candidate: does ROL(value, 2*rot) fit in 8 bits?
module val2_rot_check
    import val2_encoder_pkg::*;
(
    input  logic [31:0]       value,
    input  logic [ROT_W-1:0]  rot,
    output logic              hit,
    output logic [IMM8_W-1:0] imm8
);

    logic [31:0] rotated;

    assign rotated = rol32(value, {rot, 1'b0});
    assign hit     = (rotated[31:IMM8_W] == '0);
    assign imm8    = rotated[IMM8_W-1:0];

endmodule

// File: rtl/val2_encoder.sv
// Sequential encoder turning a 32-bit constant into the 12-bit Val2 shift_OP field,
// either as rotated immediate (multi-cycle rotate search) or as 12-bit signed offset.
module val2_encoder
    import val2_encoder_pkg::*;
#(
    parameter int CANDS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mem_mode,
    input  logic [31:0]           value,
    output logic                  busy,
    output logic                  done,
    output logic                  ok,
    output logic [SHIFT_OP_W-1:0] shift_op,
    output logic [ROT_W-1:0]      rot_count
);

    state_t                  state_reg, state_next;
    logic [31:0]             value_reg, value_next;
    logic [ROT_W-1:0]        cand_reg, cand_next;
    logic                    ok_reg, ok_next;
    logic [SHIFT_OP_W-1:0]   shift_op_reg, shift_op_next;
    logic [ROT_W-1:0]        rot_reg, rot_next;

    logic [CANDS_PER_CYCLE-1:0] hit_vec;
    logic [IMM8_W-1:0]          imm_vec [CANDS_PER_CYCLE];
    logic [ROT_W-1:0]           rot_vec [CANDS_PER_CYCLE];

    logic                    sel_hit;
    logic [IMM8_W-1:0]       sel_imm;
    logic [ROT_W-1:0]        sel_rot;
    logic                    last_group;
    logic                    mem_fits;

    generate
        for (genvar gi = 0; gi < CANDS_PER_CYCLE; gi++) begin : g_cand
            assign rot_vec[gi] = cand_reg + ROT_W'(gi);
            val2_rot_check u_rot_check (
                .value (value_reg),
                .rot   (rot_vec[gi]),
                .hit   (hit_vec[gi]),
                .imm8  (imm_vec[gi])
            );
        end
    endgenerate

    // Scan from the top down so the lowest hitting rotation overwrites the rest.
    always_comb begin
        sel_hit = 1'b0;
        sel_imm = '0;
        sel_rot = '0;
        for (int i = CANDS_PER_CYCLE - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                sel_hit = 1'b1;
                sel_imm = imm_vec[i];
                sel_rot = rot_vec[i];
            end
        end
    end

    assign last_group = (({1'b0, cand_reg} + 5'(CANDS_PER_CYCLE)) == 5'(NUM_ROT));
    assign mem_fits   = (value_reg[31:11] == {21{value_reg[11]}});

    always_comb begin
        state_next    = state_reg;
        value_next    = value_reg;
        cand_next     = cand_reg;
        ok_next       = ok_reg;
        shift_op_next = shift_op_reg;
        rot_next      = rot_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    value_next = value;
                    cand_next  = '0;
                    state_next = mem_mode ? MEMCHK : SEARCH;
                end
            end
            MEMCHK: begin
                ok_next       = mem_fits;
                shift_op_next = mem_fits ? value_reg[SHIFT_OP_W-1:0] : '0;
                rot_next      = '0;
                state_next    = DONE;
            end
            SEARCH: begin
                if (sel_hit) begin
                    ok_next       = 1'b1;
                    rot_next      = sel_rot;
                    shift_op_next = {sel_rot, sel_imm};
                    state_next    = DONE;
                end else if (last_group) begin
                    ok_next       = 1'b0;
                    rot_next      = '0;
                    shift_op_next = '0;
                    state_next    = DONE;
                end else begin
                    cand_next = cand_reg + ROT_W'(CANDS_PER_CYCLE);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            value_reg    <= '0;
            cand_reg     <= '0;
            ok_reg       <= 1'b0;
            shift_op_reg <= '0;
            rot_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            value_reg    <= value_next;
            cand_reg     <= cand_next;
            ok_reg       <= ok_next;
            shift_op_reg <= shift_op_next;
            rot_reg      <= rot_next;
        end
    end

    assign busy      = (state_reg == MEMCHK) || (state_reg == SEARCH);
    assign done      = (state_reg == DONE);
    assign ok        = ok_reg;
    assign shift_op  = shift_op_reg;
    assign rot_count = rot_reg;

endmodule

// File: tb/tb_val2_encoder.sv
// Randomized bench for val2_encoder: three instances (1, 4, 16 candidates per cycle)
// share stimulus and are compared against a round-trip Val2 reference model.
module tb_val2_encoder;
    import val2_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_mode;
    logic [31:0] value;

    logic        done_v [3];
    logic        busy_v [3];
    logic        ok_v   [3];
    logic [11:0] sop_v  [3];
    logic [3:0]  rot_v  [3];

    logic        last_ok  [3];
    logic [11:0] last_sop [3];
    int          last_lat [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    val2_encoder #(.CANDS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mem_mode(mem_mode), .value(value),
        .busy(busy_v[0]), .done(done_v[0]), .ok(ok_v[0]), .shift_op(sop_v[0]), .rot_count(rot_v[0])
    );
    val2_encoder #(.CANDS_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mem_mode(mem_mode), .value(value),
        .busy(busy_v[1]), .done(done_v[1]), .ok(ok_v[1]), .shift_op(sop_v[1]), .rot_count(rot_v[1])
    );
    val2_encoder #(.CANDS_PER_CYCLE(16)) dut2 (
        .clk(clk), .rst(rst), .start(start), .mem_mode(mem_mode), .value(value),
        .busy(busy_v[2]), .done(done_v[2]), .ok(ok_v[2]), .shift_op(sop_v[2]), .rot_count(rot_v[2])
    );

    function automatic int n_of(input int idx);
        case (idx)
            0:       return 1;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    task automatic check_val(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror_bits(input logic [31:0] x, input int amt);
        logic [31:0] y;
        y = x;
        for (int k = 0; k < amt; k++) y = {y[0], y[31:1]};
        return y;
    endfunction

    // What the execute-stage Val2 generator would produce from a shift_OP field.
    function automatic logic [31:0] val2_decode(input logic [11:0] sop, input logic m);
        if (m) return {{20{sop[11]}}, sop};
        return ror_bits({24'd0, sop[7:0]}, 2 * int'(sop[11:8]));
    endfunction

    task automatic model(input logic [31:0] v, input logic m,
                         output logic e_ok, output logic [11:0] e_sop, output logic [3:0] e_rot,
                         output int e_hit);
        int s;
        logic [31:0] r32;
        logic [7:0]  imm;
        e_ok = 1'b0; e_sop = 12'd0; e_rot = 4'd0; e_hit = -1;
        if (m) begin
            s = int'(v);
            if (s >= -2048 && s <= 2047) begin
                e_ok  = 1'b1;
                e_sop = v[11:0];
            end
        end else begin
            for (int r = 0; r < 16 && e_hit < 0; r++) begin
                r32 = rol32(v, 5'(2 * r));
                imm = r32[7:0];
                if (ror_bits({24'd0, imm}, 2 * r) == v) begin
                    e_hit = r;
                    e_ok  = 1'b1;
                    e_rot = 4'(r);
                    e_sop = {4'(r), imm};
                end
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            check_val({tag, "_busy"}, i, busy_v[i], 0);
            check_val({tag, "_done"}, i, done_v[i], 0);
            check_val({tag, "_ok"},   i, ok_v[i],   0);
            check_val({tag, "_sop"},  i, sop_v[i],  0);
            check_val({tag, "_rot"},  i, rot_v[i],  0);
        end
    endtask

    task automatic run(input logic [31:0] v, input logic m, input bit noise);
        logic        e_ok;
        logic [11:0] e_sop;
        logic [3:0]  e_rot;
        int          e_hit;
        int          e_lat [3];
        int          min_lat;
        model(v, m, e_ok, e_sop, e_rot, e_hit);
        min_lat = 100;
        for (int i = 0; i < 3; i++) begin
            if (m)              e_lat[i] = 2;
            else if (e_hit >= 0) e_lat[i] = e_hit / n_of(i) + 2;
            else                 e_lat[i] = 16 / n_of(i) + 1;
            if (e_lat[i] < min_lat) min_lat = e_lat[i];
            last_lat[i] = -1;
        end
        @(negedge clk);
        value = v; mem_mode = m; start = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            @(negedge clk);
            start = 1'b0;
            if (noise) begin
                value    = $urandom;
                mem_mode = 1'($urandom);
                if (e <= min_lat) start = 1'($urandom);
            end
            for (int i = 0; i < 3; i++) begin
                check_val("done", i, done_v[i], (e == e_lat[i]));
                check_val("busy", i, busy_v[i], (e <  e_lat[i]));
                if (done_v[i]) begin
                    last_lat[i] = e;
                    last_ok[i]  = ok_v[i];
                    last_sop[i] = sop_v[i];
                end
                if (e == e_lat[i] || e == 19) begin
                    check_val("ok",  i, ok_v[i],  e_ok);
                    check_val("sop", i, sop_v[i], e_sop);
                    check_val("rot", i, rot_v[i], e_rot);
                    if (ok_v[i]) check_val("roundtrip", i, val2_decode(sop_v[i], m), v);
                end
            end
        end
        start = 1'b0;
        $display("txn value=%08h mem=%0d ok=%0d sop=%03h lat=%0d/%0d/%0d",
                 v, m, ok_v[0], sop_v[0], last_lat[0], last_lat[1], last_lat[2]);
    endtask

    initial begin
        logic [31:0] v;
        int kind;
        rst = 1'b1; start = 1'b0; mem_mode = 1'b0; value = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        run(32'h0000_00FF, 1'b0, 1'b0);
        check_val("d_ff_sop", 0, last_sop[0], 12'h0FF);
        check_val("d_ff_ok",  0, last_ok[0], 1);
        check_val("d_ff_lat", 0, last_lat[0], 2);
        run(32'hFF00_0000, 1'b0, 1'b0);
        check_val("d_ff000000_sop", 0, last_sop[0], 12'h4FF);
        check_val("d_ff000000_lat", 0, last_lat[0], 6);
        run(32'h0000_03FC, 1'b0, 1'b0);
        check_val("d_3fc_sop", 0, last_sop[0], 12'hFFF);
        run(32'h0000_0101, 1'b0, 1'b0);
        check_val("d_101_ok",   0, last_ok[0], 0);
        check_val("d_101_sop",  0, last_sop[0], 12'h000);
        check_val("d_101_lat",  0, last_lat[0], 17);
        check_val("d_101_lat",  2, last_lat[2], 2);
        run(32'h0000_0000, 1'b0, 1'b0);
        check_val("d_zero_ok",  0, last_ok[0], 1);
        check_val("d_zero_sop", 0, last_sop[0], 12'h000);
        run(32'hFFFF_F800, 1'b1, 1'b0);
        check_val("d_m800n_sop", 0, last_sop[0], 12'h800);
        check_val("d_m800n_ok",  0, last_ok[0], 1);
        run(32'h0000_0800, 1'b1, 1'b0);
        check_val("d_m800_ok", 0, last_ok[0], 0);
        run(32'h0000_0123, 1'b1, 1'b0);
        check_val("d_m123_sop", 0, last_sop[0], 12'h123);
        check_val("d_m123_lat", 0, last_lat[0], 2);

        // Reset in the middle of a long search, with a stray start while busy.
        run(32'h0000_00FF, 1'b0, 1'b0);
        @(negedge clk);
        value = 32'h0000_0101; mem_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        value = 32'h0000_0005; mem_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1; start = 1'b1; value = 32'h0000_0123; mem_mode = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check_reset_state("midrst");
            @(negedge clk);
        end
        run(32'h0000_0123, 1'b1, 1'b0);
        check_val("post_rst_sop", 0, last_sop[0], 12'h123);

        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: v = $urandom;
                1: v = ror_bits({24'd0, 8'($urandom_range(0, 255))}, 2 * $urandom_range(0, 15));
                2: v = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: v = $urandom;
            endcase
            run(v, (kind >= 2), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
